// File: rtl/route_writeback.sv
// route_writeback: write-side endpoint of the route-optimisation stream.
// Collects one route per burst (BEATS beats of LANES city indices) from the opt datapath and
// writes each accepted beat, in order, into the route RAM through a one-register write stage.
// Optional feature macro: ROUTE_CHECK_EN (adds a city-permutation checker driving perm_err_o).
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-low reset
//   start_i     open (or restart) a route burst
//   in_valid_i  beat valid
//   in_data_i   beat, lane i at [i*CITY_W +: CITY_W]
//   wr_en_o     RAM write strobe (one cycle after acceptance)
//   wr_addr_o   RAM word address
//   wr_data_o   RAM write data
//   busy_o      burst open
//   done_o      pulse with the write of the last beat
//   ovf_err_o   sticky: beat outside a burst, or burst restarted while open
//   perm_err_o  sticky: route is not a city permutation (0 without ROUTE_CHECK_EN)
module route_writeback #(
  parameter int unsigned CITY_W = 7,
  parameter int unsigned LANES  = 8,
  parameter int unsigned BEATS  = 16,
  localparam int unsigned ADDR_W = $clog2(BEATS),
  localparam int unsigned DATA_W = LANES * CITY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_err_o,
  output logic              perm_err_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BEATS - 1);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_en_q, done_q, ovf_q, ovf_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic                is_collect, last_beat, accept, beat_to_zero, acc_last;
  logic [ADDR_W-1:0]   acc_addr;

  always_comb begin
    is_collect = (state_q == StCollect);
    last_beat  = is_collect && (cnt_q == LastAddr);
    accept     = in_valid_i && (is_collect || start_i);
    // A start coinciding with the closing beat lets that beat finish the old route at LastAddr;
    // any other start rebases the simultaneous beat to address 0.
    beat_to_zero = start_i && !last_beat;
    acc_addr     = beat_to_zero ? '0 : cnt_q;
    acc_last     = accept && (acc_addr == LastAddr);

    state_d = state_q;
    if (start_i) begin
      state_d = StCollect;
    end else if (acc_last) begin
      state_d = StIdle;
    end

    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = (accept && beat_to_zero) ? ADDR_W'(1) : '0;
    end else if (acc_last) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (start_i && !is_collect) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | (start_i && is_collect) | (in_valid_i && !is_collect && !start_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= accept;
      done_q  <= acc_last;
      ovf_q   <= ovf_d;
      if (accept) begin
        wr_addr_q <= acc_addr;
        wr_data_q <= in_data_i;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign done_o    = done_q;
  assign busy_o    = is_collect;
  assign ovf_err_o = ovf_q;

`ifdef ROUTE_CHECK_EN
  localparam int unsigned RouteLen = BEATS * LANES;

  logic [RouteLen-1:0] seen_q, seen_d, seen_base, beat_bits;
  logic [CITY_W-1:0]   lane_city;
  logic                beat_err, err_now, perm_q, perm_d;

  always_comb begin
    seen_base = beat_to_zero ? '0 : seen_q;
    beat_bits = '0;
    beat_err  = 1'b0;
    lane_city = '0;
    // beat_bits also catches two equal lanes within the same beat
    for (int i = 0; i < int'(LANES); i++) begin
      lane_city = in_data_i[i*CITY_W +: CITY_W];
      if (32'(lane_city) >= RouteLen) begin
        beat_err = 1'b1;
      end else begin
        if (seen_base[lane_city] || beat_bits[lane_city]) beat_err = 1'b1;
        beat_bits[lane_city] = 1'b1;
      end
    end
    err_now = accept && (beat_err || (acc_last && !(&(seen_base | beat_bits))));

    if (start_i && last_beat) begin
      seen_d = '0;
    end else if (accept) begin
      seen_d = seen_base | beat_bits;
    end else if (start_i) begin
      seen_d = '0;
    end else begin
      seen_d = seen_q;
    end

    perm_d = (start_i && !is_collect) ? err_now : (perm_q | err_now);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seen_q <= '0;
      perm_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
      perm_q <= perm_d;
    end
  end

  assign perm_err_o = perm_q;
`else
  assign perm_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_route_writeback.sv
module tb_route_writeback;

  localparam int CW = 7;
  localparam int DW = 56;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          wr_en_o;
  logic [3:0]    wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          ovf_err_o;
  logic          perm_err_o;

  route_writeback dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ovf_err_o  (ovf_err_o),
    .perm_err_o (perm_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ROUTE_CHECK_EN
  localparam bit ExpPerm = 1'b1;
`else
  localparam bit ExpPerm = 1'b0;
`endif

  typedef struct {
    bit            st;
    bit            vld;
    logic [DW-1:0] d;
    bit            ew;
    int            ea;
    bit            ed;
    bit            eb;
  } vec_t;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    bit            done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [DW-1:0] mk_beat(input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*CW +: CW] = CW'(8 * b + i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then score the write stage against the queue.
  task automatic step(input bit rst_v, input bit st, input bit vld, input logic [DW-1:0] d,
                      input bit ew, input int ea, input bit ed);
    exp_t e;
    bit   have;
    reset      = rst_v;
    start_i    = st;
    in_valid_i = vld;
    in_data_i  = d;
    if (ew) sb.push_back('{addr: ea, data: d, done: ed});
    @(posedge clk);
    #1;
    reset      = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    have = (sb.size() != 0);
    chk("wr_en", 64'(wr_en_o), 64'(have));
    if (have) begin
      e = sb.pop_front();
      if (wr_en_o) begin
        chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
        chk("wr_data", 64'(wr_data_o), 64'(e.data));
      end
      chk("done", 64'(done_o), 64'(e.done));
    end else begin
      chk("done_idle", 64'(done_o), 64'(0));
    end
  endtask

  initial begin
    logic [DW-1:0] bad;
    reset      = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;

    // Continuous burst, then a start-only open followed by a 1/0 valid pattern.
    for (int i = 0; i < 16; i++)
      tbl.push_back('{st: (i == 0), vld: 1'b1, d: mk_beat(i), ew: 1'b1, ea: i,
                      ed: (i == 15), eb: (i != 15)});
    tbl.push_back('{st: 1'b1, vld: 1'b0, d: '0, ew: 1'b0, ea: 0, ed: 1'b0, eb: 1'b1});
    for (int k = 0; k < 32; k++) begin
      bit v;
      v = (k % 2 == 0);
      tbl.push_back('{st: 1'b0, vld: v, d: v ? mk_beat(k / 2) : '0, ew: v, ea: k / 2,
                      ed: v && (k / 2 == 15), eb: (k < 30)});
    end

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en_o), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr_o), 64'(0));
    chk("rst_wr_data", 64'(wr_data_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_ovf", 64'(ovf_err_o), 64'(0));
    chk("rst_perm", 64'(perm_err_o), 64'(0));
    reset = 1'b1;

    foreach (tbl[j]) begin
      step(1'b1, tbl[j].st, tbl[j].vld, tbl[j].d, tbl[j].ew, tbl[j].ea, tbl[j].ed);
      chk("busy", 64'(busy_o), 64'(tbl[j].eb));
      chk("ovf_clean", 64'(ovf_err_o), 64'(0));
      chk("perm_clean", 64'(perm_err_o), 64'(0));
    end

    // Valid beat in IDLE: dropped, sticky overflow until next start from IDLE.
    step(1'b1, 1'b0, 1'b1, mk_beat(3), 1'b0, 0, 1'b0);
    chk("idle_beat_ovf", 64'(ovf_err_o), 64'(1));
    chk("idle_beat_busy", 64'(busy_o), 64'(0));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
    chk("ovf_sticky", 64'(ovf_err_o), 64'(1));
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
    chk("ovf_clear_on_start", 64'(ovf_err_o), 64'(0));
    chk("busy_after_start", 64'(busy_o), 64'(1));

    // Restart mid-burst: 5 beats, then start + beat lands at address 0.
    for (int b = 0; b < 5; b++) step(1'b1, 1'b0, 1'b1, mk_beat(b), 1'b1, b, 1'b0);
    chk("ovf_before_restart", 64'(ovf_err_o), 64'(0));
    step(1'b1, 1'b1, 1'b1, mk_beat(0), 1'b1, 0, 1'b0);
    chk("ovf_restart", 64'(ovf_err_o), 64'(1));
    chk("busy_restart", 64'(busy_o), 64'(1));
    for (int b = 1; b < 16; b++) begin
      step(1'b1, 1'b0, 1'b1, mk_beat(b), 1'b1, b, (b == 15));
      chk("busy_after_restart", 64'(busy_o), 64'(b != 15));
    end
    chk("ovf_held", 64'(ovf_err_o), 64'(1));
    chk("perm_restart_route", 64'(perm_err_o), 64'(0));
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
    chk("ovf_clear2", 64'(ovf_err_o), 64'(0));

    // Reset during beat 7: write squashed, burst abandoned, next burst from address 0.
    for (int b = 0; b < 7; b++) step(1'b1, 1'b0, 1'b1, mk_beat(b), 1'b1, b, 1'b0);
    step(1'b0, 1'b0, 1'b1, mk_beat(7), 1'b0, 0, 1'b0);
    chk("rst_mid_busy", 64'(busy_o), 64'(0));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
    chk("rst_mid_idle", 64'(busy_o), 64'(0));
    step(1'b1, 1'b1, 1'b1, mk_beat(0), 1'b1, 0, 1'b0);
    for (int b = 1; b < 16; b++) step(1'b1, 1'b0, 1'b1, mk_beat(b), 1'b1, b, (b == 15));
    chk("rst_mid_done_busy", 64'(busy_o), 64'(0));
    chk("rst_mid_ovf", 64'(ovf_err_o), 64'(0));

    // Duplicate city: beat 3 lane 2 = 5 repeats beat 0 lane 5.
    step(1'b1, 1'b1, 1'b1, mk_beat(0), 1'b1, 0, 1'b0);
    for (int b = 1; b < 3; b++) step(1'b1, 1'b0, 1'b1, mk_beat(b), 1'b1, b, 1'b0);
    chk("perm_before_dup", 64'(perm_err_o), 64'(0));
    bad = mk_beat(3);
    bad[2*CW +: CW] = CW'(5);
    step(1'b1, 1'b0, 1'b1, bad, 1'b1, 3, 1'b0);
    chk("perm_dup", 64'(perm_err_o), 64'(ExpPerm));
    for (int b = 4; b < 16; b++) step(1'b1, 1'b0, 1'b1, mk_beat(b), 1'b1, b, (b == 15));
    chk("perm_sticky", 64'(perm_err_o), 64'(ExpPerm));
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
    chk("perm_clear", 64'(perm_err_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
